// File: rtl/can_rx_pkg.sv
// Shared types and defaults for the CAN receive/destuff path.
package can_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, DONE, ERROR} state_t;

    localparam int FRAME_BITS_DEF  = 108;
    localparam int STUFF_LIMIT_DEF = 5;

    function automatic int cnt_width(input int clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction
endpackage

// File: rtl/can_stuff_monitor.sv
// Tracks the run of equal bits on the line and classifies each sampled bit
// as data, stuff bit, or stuff-rule violation.
module can_stuff_monitor #(
    parameter int STUFF_LIMIT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic strobe,
    input  logic sample,
    output logic is_stuff,
    output logic is_error
);
    localparam int LW = $clog2(STUFF_LIMIT + 1);

    logic          run_val;
    logic [LW-1:0] run_len;
    logic          at_limit;

    assign at_limit = (run_len == LW'(STUFF_LIMIT));
    assign is_stuff = strobe && at_limit && (sample != run_val);
    assign is_error = strobe && at_limit && (sample == run_val);

    // A zero run length marks "no bit seen yet", so the SOF starts a fresh run.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_val <= 1'b0;
            run_len <= '0;
        end else if (strobe && !is_error) begin
            if (run_len != '0 && sample == run_val) begin
                run_len <= run_len + LW'(1);
            end else begin
                run_val <= sample;
                run_len <= LW'(1);
            end
        end
    end
endmodule

// File: rtl/can_rx_destuff.sv
// CAN bit receiver: SOF detection, mid-bit sampling, destuffing, frame capture.
// Define CAN_RX_SYNC_EN to route the bus line through a 2-flop synchronizer.
module can_rx_destuff import can_rx_pkg::*; #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FRAME_BITS   = FRAME_BITS_DEF,
    parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Rx_Serial,
    output logic                  o_Rx_DV,
    output logic [FRAME_BITS-1:0] o_Rx_Byte,
    output logic                  o_Ignora_Bit,
    output logic                  o_Eror_Stuffing
);
    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int IW = $clog2(FRAME_BITS + 1);

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx;
    logic [FRAME_BITS-1:0] frame;
    logic                  rx, prev, ign;
    logic                  strobe, sof_ok, store;
    logic                  is_stuff, is_error;

`ifdef CAN_RX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge i_Clock) begin
        if (i_Reset) sync <= '0;
        else         sync <= {sync[0], i_Rx_Serial};
    end
    assign rx = sync[1];
`else
    assign rx = i_Rx_Serial;
`endif

    can_stuff_monitor #(.STUFF_LIMIT(STUFF_LIMIT)) u_mon (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .clear    (state == IDLE),
        .strobe   (strobe),
        .sample   (rx),
        .is_stuff (is_stuff),
        .is_error (is_error)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        strobe  = 1'b0;
        sof_ok  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (prev && !rx) state_n = START;
            end
            START: begin
                if (cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
                    cnt_n = '0;
                    if (!rx) begin
                        state_n = DATA;
                        strobe  = 1'b1;
                        sof_ok  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n  = '0;
                    strobe = 1'b1;
                    if (is_error)
                        state_n = ERROR;
                    else if (!is_stuff && idx == IW'(FRAME_BITS - 1))
                        state_n = DONE;
                end
            end
            DONE, ERROR: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign store = strobe && !sof_ok && !is_stuff && !is_error;

    // The frame register is wiped at SOF so a stale frame is visible until then.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            prev  <= 1'b0;
            idx   <= '0;
            frame <= '0;
            ign   <= 1'b0;
        end else begin
            prev <= rx;
            ign  <= is_stuff;
            if (sof_ok) begin
                frame <= '0;
                idx   <= IW'(1);
            end else if (store) begin
                frame[idx] <= rx;
                idx        <= idx + IW'(1);
            end
        end
    end

    assign o_Rx_DV         = (state == DONE);
    assign o_Eror_Stuffing = (state == ERROR);
    assign o_Ignora_Bit    = ign;
    assign o_Rx_Byte       = frame;
endmodule

// File: tb/tb_can_rx_destuff.sv
// Directed bench for can_rx_destuff with a frame scoreboard and pulse monitor.
module tb_can_rx_destuff;
    import can_rx_pkg::*;

    localparam int CPB = 10;
    localparam int FB  = 108;
`ifdef CAN_RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          dv, ign, err;
    logic [FB-1:0] rx_byte;

    can_rx_destuff #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .STUFF_LIMIT(5)) dut (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_Rx_Serial     (rx),
        .o_Rx_DV         (dv),
        .o_Rx_Byte       (rx_byte),
        .o_Ignora_Bit    (ign),
        .o_Eror_Stuffing (err)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [FB-1:0] frame;
        int            dv_cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    bit            line_q[$];
    logic [FB-1:0] exp_frame;
    int            cyc = 0;
    int            checks = 0, errors = 0;
    int            ign_cnt = 0, err_cnt = 0;
    int            last_ign_cyc = -1, last_err_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every DV and tallies the pulse outputs.
    always @(negedge clk) begin
        if (ign === 1'b1) begin ign_cnt++; last_ign_cyc = cyc; end
        if (err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
        if (dv === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dv: got DV at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("frame", rx_byte, e.frame);
                chk("dv_latency", FB'(cyc), FB'(e.dv_cyc));
            end
        end
    end

    // Drives the first n bits of line_q; start is the cycle the SOF edge is driven.
    task automatic drive(input int n, input bit push, input int nlines, output int start);
        @(posedge clk); #1;
        start = cyc;
        if (push) sb.push_back('{exp_frame, start + 1 + CPB/2 + (nlines - 1)*CPB + SYNC});
        for (int i = 0; i < n; i++) begin
            rx = line_q[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build_clean();
        line_q.delete();
        for (int i = 0; i < FB; i++) begin
            line_q.push_back(bit'(i % 2));
            exp_frame[i] = logic'(i % 2);
        end
    endtask

    initial begin
        #(100 * 50000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int st, i0, e0;

        // Reset with recessive line
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dv", FB'(dv), '0);
        chk("rst_byte", rx_byte, '0);
        chk("rst_ign", FB'(ign), '0);
        chk("rst_err", FB'(err), '0);
        chk("rst_state", FB'(dut.state), FB'(IDLE));
        rst = 1'b0;
        idle(200);
        chk("idle_pulses", FB'(ign_cnt + err_cnt), '0);

        // Clean alternating frame
        build_clean();
        i0 = ign_cnt; e0 = err_cnt;
        drive(FB, 1'b1, FB, st);
        idle(30);
        chk("clean_dv_seen", FB'(sb.size()), '0);
        chk("clean_ign", FB'(ign_cnt - i0), '0);
        chk("clean_err", FB'(err_cnt - e0), '0);
        chk("clean_hold", rx_byte, exp_frame);

        // Stuffed frame: 5 zeros, stuff 1, then alternating from 1
        line_q.delete();
        exp_frame = '0;
        for (int i = 0; i < 5; i++) line_q.push_back(1'b0);
        line_q.push_back(1'b1);
        for (int j = 0; j < FB - 5; j++) begin
            line_q.push_back(bit'((j % 2) == 0));
            exp_frame[5 + j] = logic'((j % 2) == 0);
        end
        i0 = ign_cnt; e0 = err_cnt;
        drive(FB + 1, 1'b1, FB + 1, st);
        idle(30);
        chk("stuff_dv_seen", FB'(sb.size()), '0);
        chk("stuff_ign", FB'(ign_cnt - i0), FB'(1));
        chk("stuff_ign_time", FB'(last_ign_cyc), FB'(st + 1 + CPB/2 + 5*CPB + SYNC));
        chk("stuff_err", FB'(err_cnt - e0), '0);

        // Stuff error: six dominant bits from SOF
        line_q.delete();
        for (int i = 0; i < 6; i++) line_q.push_back(1'b0);
        i0 = ign_cnt; e0 = err_cnt;
        drive(6, 1'b0, 6, st);
        idle(40);
        chk("err_pulse", FB'(err_cnt - e0), FB'(1));
        chk("err_time", FB'(last_err_cyc), FB'(st + 1 + CPB/2 + 5*CPB + SYNC));
        chk("err_ign", FB'(ign_cnt - i0), '0);
        chk("err_partial", rx_byte, '0);
        chk("err_state", FB'(dut.state), FB'(IDLE));

        build_clean();
        drive(FB, 1'b1, FB, st);
        idle(30);
        chk("post_err_dv_seen", FB'(sb.size()), '0);

        // Glitch: 3 dominant clocks only
        i0 = ign_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(30);
        chk("glitch_pulses", FB'((ign_cnt - i0) + (err_cnt - e0)), '0);
        chk("glitch_state", FB'(dut.state), FB'(IDLE));
        chk("glitch_hold", rx_byte, exp_frame);

        // Reset mid-frame
        build_clean();
        drive(50, 1'b0, FB, st);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_byte", rx_byte, '0);
        chk("midrst_dv", FB'(dv), '0);
        chk("midrst_state", FB'(dut.state), FB'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(30);
        i0 = ign_cnt; e0 = err_cnt;
        drive(FB, 1'b1, FB, st);
        idle(30);
        chk("post_rst_dv_seen", FB'(sb.size()), '0);
        chk("post_rst_pulses", FB'((ign_cnt - i0) + (err_cnt - e0)), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
